// File: rtl/bcd2_seg7_scan_pkg.sv
// Shared display definitions: active-high segment patterns {g,f,e,d,c,b,a},
// the digit-select encoding and active-high anode enables {tens, ones}.
package bcd2_seg7_scan_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic {
        SEL_ONES = 1'b0,
        SEL_TENS = 1'b1
    } sel_e;

    localparam logic [1:0] AN_NONE = 2'b00;
    localparam logic [1:0] AN_ONES = 2'b01;
    localparam logic [1:0] AN_TENS = 2'b10;

endpackage

// File: rtl/bcd2_seg7_scan_bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; codes A..F show a dash.
module bcd_to_seg7
    import bcd2_seg7_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd2_seg7_scan.sv
// Two-digit multiplexed 7-segment scanner with per-frame digit shadowing.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is 0.
module bcd2_seg7_scan
    import bcd2_seg7_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] dig1,
    input  logic [3:0] dig0,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned    CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [1:0]     AN_IDLE  = ACTIVE_LOW ? ~AN_NONE : AN_NONE;

    logic [CW-1:0] cnt_q, cnt_d;
    sel_e          sel_q, sel_d;
    logic [3:0]    sh1_q, sh1_d;
    logic [3:0]    sh0_q, sh0_d;
    logic          load_pend_q, load_pend_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    logic [3:0]    shown_digit;
    logic [6:0]    shown_pat;
    logic [6:0]    pat;
    logic [1:0]    an_hi;
    logic          term;

    assign shown_digit = (sel_q == SEL_TENS) ? sh1_q : sh0_q;

    bcd_to_seg7 u_dec (
        .bcd_i (shown_digit),
        .seg_o (shown_pat)
    );

    always_comb begin
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        sh1_d       = sh1_q;
        sh0_d       = sh0_q;
        load_pend_d = load_pend_q;
        term        = (cnt_q == CNT_LAST);

        // Prescaler holds during the post-reset load cycle so the first ones slot is full length
        if (load_pend_q) begin
            load_pend_d = 1'b0;
            sh1_d       = dig1;
            sh0_d       = dig0;
        end else begin
            cnt_d = term ? '0 : cnt_q + CW'(1);
            if (term) begin
                sel_d = (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
                if (sel_q == SEL_TENS) begin
                    sh1_d = dig1;
                    sh0_d = dig0;
                end
            end
        end
    end

    always_comb begin
        pat   = shown_pat;
        an_hi = (sel_q == SEL_TENS) ? AN_TENS : AN_ONES;
        if (load_pend_q) begin
            pat   = SEG_OFF;
            an_hi = AN_NONE;
        end
`ifdef LEADING_ZERO_BLANK_EN
        else if (sel_q == SEL_TENS && sh1_q == 4'd0) begin
            pat   = SEG_OFF;
            an_hi = AN_NONE;
        end
`endif
        seg_d = ACTIVE_LOW ? ~pat : pat;
        an_d  = ACTIVE_LOW ? ~an_hi : an_hi;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            sel_q       <= SEL_ONES;
            sh1_q       <= '0;
            sh0_q       <= '0;
            load_pend_q <= 1'b1;
            seg_q       <= SEG_IDLE;
            an_q        <= AN_IDLE;
        end else begin
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            sh1_q       <= sh1_d;
            sh0_q       <= sh0_d;
            load_pend_q <= load_pend_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_bcd2_seg7_scan.sv
// Self-checking bench for bcd2_seg7_scan (SCAN_DIV=4, active-low outputs).
// Expected outputs come from a frame-based timing model fed through a scoreboard queue.
module tb_bcd2_seg7_scan;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dig1, dig0;
    logic [6:0] seg;
    logic [1:0] an;

    always #10 clk = ~clk;

    bcd2_seg7_scan #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut (
        .clock (clk),
        .reset (reset),
        .dig1  (dig1),
        .dig0  (dig0),
        .seg   (seg),
        .an    (an)
    );

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
    } exp_t;

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d0;
        logic [6:0] tens_seg;
        logic [6:0] ones_seg;
    } vec_t;

    exp_t       sbq[$];
    logic [6:0] seg_al [16];
    int         errors;
    int         checks;
    int         k;
    logic [3:0] fd1, fd0;
    logic [6:0] last_tens, last_ones;

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, push the model's expectation, compare after the edge
    task automatic step(input logic rst, input logic [3:0] d1, input logic [3:0] d0);
        exp_t e;
        int   slot;
        reset = rst;
        dig1  = d1;
        dig0  = d0;
        e.an  = 2'b11;
        e.seg = 7'h7F;
        if (rst) begin
            k = -1;
        end else begin
            k++;
            if (k > 0) begin
                slot = (k - 1) / SD;
                if ((slot % 2) == 1) begin
                    e.an  = 2'b01;
                    e.seg = seg_al[fd1];
`ifdef LEADING_ZERO_BLANK_EN
                    if (fd1 == 4'd0) begin
                        e.an  = 2'b11;
                        e.seg = 7'h7F;
                    end
`endif
                end else begin
                    e.an  = 2'b10;
                    e.seg = seg_al[fd0];
                end
            end
            if ((k % (2 * SD)) == 0) begin
                fd1 = d1;
                fd0 = d0;
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("scan_an", {5'b0, an}, {5'b0, e.an});
        chk("scan_seg", seg, e.seg);
        if (an == 2'b01) last_tens = seg;
        if (an == 2'b10) last_ones = seg;
    endtask

    vec_t vecs [6];
    logic [3:0] c1, c0;

    initial begin
        errors = 0;
        checks = 0;
        k      = -1;
        fd1    = '0;
        fd0    = '0;
        last_tens = 7'h7F;
        last_ones = 7'h7F;
        reset  = 1'b1;
        dig1   = '0;
        dig0   = '0;

        seg_al[0]  = 7'h40; seg_al[1]  = 7'h79; seg_al[2]  = 7'h24; seg_al[3]  = 7'h30;
        seg_al[4]  = 7'h19; seg_al[5]  = 7'h12; seg_al[6]  = 7'h02; seg_al[7]  = 7'h78;
        seg_al[8]  = 7'h00; seg_al[9]  = 7'h10;
        for (int i = 10; i < 16; i++) seg_al[i] = 7'h3F;

        vecs[0] = '{d1: 4'd3, d0: 4'd7, tens_seg: 7'h30, ones_seg: 7'h78};
        vecs[1] = '{d1: 4'hC, d0: 4'd9, tens_seg: 7'h3F, ones_seg: 7'h10};
        vecs[2] = '{d1: 4'd9, d0: 4'd0, tens_seg: 7'h10, ones_seg: 7'h40};
        vecs[3] = '{d1: 4'd8, d0: 4'd1, tens_seg: 7'h00, ones_seg: 7'h79};
        vecs[4] = '{d1: 4'd6, d0: 4'd2, tens_seg: 7'h02, ones_seg: 7'h24};
        vecs[5] = '{d1: 4'hF, d0: 4'hA, tens_seg: 7'h3F, ones_seg: 7'h3F};

        // Power-on reset with 3/7, then scan
        repeat (5) step(1'b1, 4'd3, 4'd7);
        chk("reset_an", {5'b0, an}, 7'h03);
        chk("reset_seg", seg, 7'h7F);
        step(1'b0, 4'd3, 4'd7);
        chk("release_blank_an", {5'b0, an}, 7'h03);
        step(1'b0, 4'd3, 4'd7);
        chk("first_ones_an", {5'b0, an}, 7'h02);
        chk("first_ones_seg", seg, 7'h78);
        repeat (15) step(1'b0, 4'd3, 4'd7);
        chk("first_tens_seg", last_tens, 7'h30);

        // dig0 changes mid ones slot: held until the next frame end
        step(1'b0, 4'd3, 4'd7);
        repeat (7) step(1'b0, 4'd3, 4'd4);
        chk("midframe_hold", last_ones, 7'h78);
        repeat (4) step(1'b0, 4'd3, 4'd4);
        chk("midframe_update", last_ones, 7'h19);

        for (int v = 0; v < 6; v++) begin
            repeat (6 * SD) step(1'b0, vecs[v].d1, vecs[v].d0);
            chk("vec_tens", last_tens, vecs[v].tens_seg);
            chk("vec_ones", last_ones, vecs[v].ones_seg);
        end

        // One-cycle reset in a tens slot
        while (!(k > 0 && (((k - 1) / SD) % 2) == 1 && ((k - 1) % SD) == 1))
            step(1'b0, 4'd4, 4'd5);
        step(1'b1, 4'd4, 4'd5);
        chk("midreset_an", {5'b0, an}, 7'h03);
        chk("midreset_seg", seg, 7'h7F);
        step(1'b0, 4'd4, 4'd5);
        step(1'b0, 4'd4, 4'd5);
        chk("restart_ones_an", {5'b0, an}, 7'h02);
        chk("restart_ones_seg", seg, 7'h12);

        // Leading zero
        last_tens = 7'h7F;
        repeat (6 * SD) step(1'b0, 4'd0, 4'd5);
        chk("lz_ones", last_ones, 7'h12);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_tens_blank", last_tens, 7'h7F);
`else
        chk("lz_tens_zero", last_tens, 7'h40);
`endif

        // Counter-driven stream
        c1 = '0;
        c0 = '0;
        for (int t = 0; t < 300; t++) begin
            step(1'b0, c1, c0);
            chk("an_never_both", {6'b0, an == 2'b00}, 7'h00);
            if ((t % 7) == 6) begin
                if (c0 == 4'd9) begin
                    c0 = '0;
                    c1 = (c1 == 4'd9) ? 4'd0 : c1 + 4'd1;
                end else begin
                    c0 = c0 + 4'd1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
